// File: rtl/pipe_stage_ctrl.sv
// IF/ID and ID/EX pipeline registers with hazard-unit stall/bubble/flush
// control, plus saturating stall and flush event counters.
module pipe_stage_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      IF_Instr,
  input  logic [31:0]      IF_PC4,
  input  logic             ID_Write,
  input  logic             nop_mux,
  input  logic             flush,
  input  logic [9:0]       ID_Ctrl,
  input  logic [31:0]      ID_RegA,
  input  logic [31:0]      ID_RegB,
  input  logic [31:0]      ID_Imm,
  output logic             PC_Write,
  output logic [31:0]      ID_Instr,
  output logic [31:0]      ID_PC4,
  output logic [9:0]       EX_Ctrl,
  output logic [31:0]      EX_RegA,
  output logic [31:0]      EX_RegB,
  output logic [31:0]      EX_Imm,
  output logic [4:0]       EX_rs,
  output logic [4:0]       EX_rt,
  output logic [4:0]       EX_rd,
  output logic             EX_MemRead,
  output logic             EX_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned XLEN        = 32;
  localparam int unsigned CTRL_W      = 10;
  localparam int unsigned REG_W       = 5;
  localparam int unsigned MEMREAD_BIT = 7;
  localparam int unsigned RS_LSB      = 21;
  localparam int unsigned RT_LSB      = 16;
  localparam int unsigned RD_LSB      = 11;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic id_valid;
  logic bubble_c;
  logic stall_c;
  logic flush_ok_c;

  // Fetch may advance only when IF/ID advances; always enabled in reset.
  assign PC_Write   = reset ? 1'b1 : ID_Write;

  // A bubble enters EX on an explicit hazard request or when ID is empty.
  assign bubble_c   = nop_mux | ~id_valid;

  // Stall and accepted-flush events; a flush under a hold is discarded.
  assign stall_c    = ~ID_Write;
  assign flush_ok_c = flush & ID_Write;

  // Load-use indication for the hazard unit; zero on every bubble.
  assign EX_MemRead = EX_Ctrl[MEMREAD_BIT];

  // IF/ID register: hold beats flush, flush beats load.
  always_ff @(posedge clk) begin
    if (reset) begin
      ID_Instr <= '0;
      ID_PC4   <= '0;
      id_valid <= 1'b0;
    end else if (ID_Write) begin
      if (flush) begin
        ID_Instr <= '0;
        ID_PC4   <= '0;
        id_valid <= 1'b0;
      end else begin
        ID_Instr <= IF_Instr;
        ID_PC4   <= IF_PC4;
        id_valid <= 1'b1;
      end
    end
  end

  // ID/EX register: updates every cycle, zeroed on a bubble.
  always_ff @(posedge clk) begin
    if (reset || bubble_c) begin
      EX_Ctrl  <= CTRL_W'(0);
      EX_RegA  <= XLEN'(0);
      EX_RegB  <= XLEN'(0);
      EX_Imm   <= XLEN'(0);
      EX_rs    <= REG_W'(0);
      EX_rt    <= REG_W'(0);
      EX_rd    <= REG_W'(0);
      EX_valid <= 1'b0;
    end else begin
      EX_Ctrl  <= ID_Ctrl;
      EX_RegA  <= ID_RegA;
      EX_RegB  <= ID_RegB;
      EX_Imm   <= ID_Imm;
      EX_rs    <= ID_Instr[RS_LSB +: REG_W];
      EX_rt    <= ID_Instr[RT_LSB +: REG_W];
      EX_rd    <= ID_Instr[RD_LSB +: REG_W];
      EX_valid <= 1'b1;
    end
  end

  // Stall-cycle counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall_c && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // Accepted-flush counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_cnt <= '0;
    end else if (flush_ok_c && (flush_cnt != CNT_MAX)) begin
      flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Bench for pipe_stage_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared each cycle against a behavioural model.
module tb_pipe_stage_ctrl;

  localparam int unsigned CW  = 4;
  localparam int          MAXC = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IF_Instr, IF_PC4, ID_RegA, ID_RegB, ID_Imm;
  logic        ID_Write, nop_mux, flush;
  logic [9:0]  ID_Ctrl;
  logic        PC_Write, EX_MemRead, EX_valid;
  logic [31:0] ID_Instr, ID_PC4, EX_RegA, EX_RegB, EX_Imm;
  logic [9:0]  EX_Ctrl;
  logic [4:0]  EX_rs, EX_rt, EX_rd;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  pipe_stage_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .IF_Instr(IF_Instr), .IF_PC4(IF_PC4),
    .ID_Write(ID_Write), .nop_mux(nop_mux), .flush(flush), .ID_Ctrl(ID_Ctrl),
    .ID_RegA(ID_RegA), .ID_RegB(ID_RegB), .ID_Imm(ID_Imm),
    .PC_Write(PC_Write), .ID_Instr(ID_Instr), .ID_PC4(ID_PC4),
    .EX_Ctrl(EX_Ctrl), .EX_RegA(EX_RegA), .EX_RegB(EX_RegB), .EX_Imm(EX_Imm),
    .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_rd(EX_rd), .EX_MemRead(EX_MemRead),
    .EX_valid(EX_valid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the stages hold, in plain terms.
  logic [31:0] m_id_instr, m_id_pc4;
  bit          m_id_full;
  bit          m_ex_full;
  logic [31:0] m_ex_instr, m_ex_a, m_ex_b, m_ex_imm;
  logic [9:0]  m_ex_ctrl;
  int          m_stalls, m_flushes;

  always @(posedge clk) begin
    if (reset) begin
      m_id_instr = 0; m_id_pc4 = 0; m_id_full = 0;
      m_ex_full = 0; m_ex_instr = 0; m_ex_a = 0; m_ex_b = 0; m_ex_imm = 0;
      m_ex_ctrl = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      // EX takes what ID holds now, unless a bubble is requested or ID is empty.
      if (nop_mux || !m_id_full) begin
        m_ex_full = 0; m_ex_instr = 0; m_ex_a = 0; m_ex_b = 0; m_ex_imm = 0; m_ex_ctrl = 0;
      end else begin
        m_ex_full = 1; m_ex_instr = m_id_instr; m_ex_a = ID_RegA;
        m_ex_b = ID_RegB; m_ex_imm = ID_Imm; m_ex_ctrl = ID_Ctrl;
      end
      if (!ID_Write) begin
        if (m_stalls < MAXC) m_stalls = m_stalls + 1;
      end else if (flush) begin
        m_id_instr = 0; m_id_pc4 = 0; m_id_full = 0;
        if (m_flushes < MAXC) m_flushes = m_flushes + 1;
      end else begin
        m_id_instr = IF_Instr; m_id_pc4 = IF_PC4; m_id_full = 1;
      end
    end
  end

  // Compare process, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("PC_Write",   32'(PC_Write),   reset ? 32'd1 : 32'(ID_Write));
      chk("ID_Instr",   ID_Instr,        m_id_instr);
      chk("ID_PC4",     ID_PC4,          m_id_pc4);
      chk("EX_Ctrl",    32'(EX_Ctrl),    32'(m_ex_ctrl));
      chk("EX_RegA",    EX_RegA,         m_ex_a);
      chk("EX_RegB",    EX_RegB,         m_ex_b);
      chk("EX_Imm",     EX_Imm,          m_ex_imm);
      chk("EX_rs",      32'(EX_rs),      (m_ex_instr >> 21) & 32'd31);
      chk("EX_rt",      32'(EX_rt),      (m_ex_instr >> 16) & 32'd31);
      chk("EX_rd",      32'(EX_rd),      (m_ex_instr >> 11) & 32'd31);
      chk("EX_MemRead", 32'(EX_MemRead), (32'(m_ex_ctrl) >> 7) & 32'd1);
      chk("EX_valid",   32'(EX_valid),   32'(m_ex_full));
      chk("stall_cnt",  32'(stall_cnt),  32'(m_stalls));
      chk("flush_cnt",  32'(flush_cnt),  32'(m_flushes));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit rst, input bit wr, input bit nop, input bit fl,
                       input logic [31:0] instr);
    reset = rst; ID_Write = wr; nop_mux = nop; flush = fl; IF_Instr = instr;
  endtask

  initial begin
    drive(1, 1, 0, 0, 32'h0);
    IF_PC4 = 32'h4; ID_Ctrl = 10'h2A8; ID_RegA = 32'hAAAA0001;
    ID_RegB = 32'hBBBB0002; ID_Imm = 32'hFFFF_FFF0;

    // Reset for two cycles.
    tick(); tick();
    chk_en = 1'b1;
    chk("rst_ID_Instr", ID_Instr, 32'h0);
    chk("rst_EX_valid", 32'(EX_valid), 32'h0);
    chk("rst_EX_Ctrl",  32'(EX_Ctrl), 32'h0);
    chk("rst_stall",    32'(stall_cnt), 32'h0);
    chk("rst_PC_Write", 32'(PC_Write), 32'h1);

    // Load-use stall on 0x01095020.
    drive(0, 1, 0, 0, 32'h01095020); IF_PC4 = 32'h104;
    tick();
    chk("lu_ID_Instr", ID_Instr, 32'h01095020);
    drive(0, 0, 1, 0, 32'h0);
    #1 chk("lu_PC_Write", 32'(PC_Write), 32'h0);
    tick();
    chk("lu_hold",      ID_Instr, 32'h01095020);
    chk("lu_EX_Ctrl",   32'(EX_Ctrl), 32'h0);
    chk("lu_EX_valid",  32'(EX_valid), 32'h0);
    chk("lu_MemRead",   32'(EX_MemRead), 32'h0);
    chk("lu_stall",     32'(stall_cnt), 32'h1);
    drive(0, 1, 0, 0, 32'h0);
    tick();
    chk("lu_EX_rd",     32'(EX_rd), 32'd10);
    chk("lu_EX_rs",     32'(EX_rs), 32'd8);
    chk("lu_EX_rt",     32'(EX_rt), 32'd9);
    chk("lu_EX_valid1", 32'(EX_valid), 32'h1);
    chk("lu_MemRead1",  32'(EX_MemRead), 32'h1);

    // Accepted flush.
    drive(0, 1, 0, 1, 32'h8C080004);
    tick();
    chk("fl_ID_Instr", ID_Instr, 32'h0);
    chk("fl_cnt",      32'(flush_cnt), 32'h1);
    drive(0, 1, 0, 0, 32'h0);
    tick();
    chk("fl_EX_valid", 32'(EX_valid), 32'h0);

    // Flush under a hold is ignored.
    drive(0, 1, 0, 0, 32'h12345678);
    tick();
    drive(0, 0, 0, 1, 32'h0);
    tick();
    chk("hf_ID_Instr", ID_Instr, 32'h12345678);
    chk("hf_flush",    32'(flush_cnt), 32'h1);
    chk("hf_stall",    32'(stall_cnt), 32'h2);

    // Reset in the 2nd cycle of a 3-cycle stall.
    drive(0, 0, 0, 0, 32'h0);
    tick();
    drive(1, 0, 0, 0, 32'h0);
    tick();
    chk("rs_ID_Instr", ID_Instr, 32'h0);
    chk("rs_EX_valid", 32'(EX_valid), 32'h0);
    chk("rs_stall",    32'(stall_cnt), 32'h0);

    // Stall counter saturation.
    drive(0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 20; i++) tick();
    chk("sat_stall", 32'(stall_cnt), 32'hF);
    tick();
    chk("sat_hold",  32'(stall_cnt), 32'hF);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 97) == 0, ($urandom % 4) != 0, ($urandom % 5) == 0,
            ($urandom % 6) == 0, $urandom);
      IF_PC4  = $urandom; ID_Ctrl = 10'($urandom);
      ID_RegA = $urandom; ID_RegB = $urandom; ID_Imm = $urandom;
      tick();
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_ctrl.md
PIPE_STAGE_CTRL -- requirements
Module: pipe_stage_ctrl

Interface
REQ-001 Parameter: CNT_W, default 16, width of the stall and flush event counters.
REQ-002 Reset is reset, synchronous, active-high; the clock is clk.
REQ-003 Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-high.
- IF_Instr  in  32  fetched instruction.
- IF_PC4  in  32  fetch PC+4.
- ID_Write  in  1  from hazard unit; 1=advance IF/ID, 0=hold.
- nop_mux  in  1  from hazard unit; 1=insert bubble into ID/EX.
- flush  in  1  taken branch/jump resolved in ID; kill IF/ID.
- ID_Ctrl  in  10  decoder control word; see REQ-004.
- ID_RegA  in  32  register-file read data A.
- ID_RegB  in  32  register-file read data B.
- ID_Imm  in  32  sign-extended immediate.
- PC_Write  out  1  PC enable to fetch.
- ID_Instr  out  32  IF/ID instruction.
- ID_PC4  out  32  IF/ID PC+4.
- EX_Ctrl  out  10  ID/EX control word.
- EX_RegA  out  32  ID/EX operand A.
- EX_RegB  out  32  ID/EX operand B.
- EX_Imm  out  32  ID/EX immediate.
- EX_rs  out  5  ID/EX rs field.
- EX_rt  out  5  ID/EX rt field; fed back to the hazard unit.
- EX_rd  out  5  ID/EX rd field.
- EX_MemRead  out  1  EX_Ctrl[7]; fed back to the hazard unit.
- EX_valid  out  1  1 = EX holds a real instruction.
- stall_cnt  out  CNT_W  stall-cycle count.
- flush_cnt  out  CNT_W  accepted-flush count.
REQ-004 ID_Ctrl/EX_Ctrl bit map: [9] RegWrite, [8] MemtoReg, [7] MemRead, [6] MemWrite, [5] Branch, [4] RegDst, [3] ALUSrc, [2:1] ALUOp, [0] Jump.

Function
REQ-005 PC_Write SHALL equal ID_Write combinationally, forced to 1 while reset=1.
REQ-006 The IF/ID register SHALL hold an internal ID_valid bit alongside ID_Instr and ID_PC4.
REQ-007 IF/ID priority, highest first:
- reset: ID_Instr=0, ID_PC4=0, ID_valid=0.
- ID_Write=0: hold all fields; flush ignored.
- flush=1: ID_Instr=0, ID_PC4=0, ID_valid=0.
- otherwise: load IF_Instr and IF_PC4; ID_valid=1.
REQ-008 When ID_Write=0 and flush=1 in the same cycle, the hold SHALL win and the flush SHALL NOT be counted.
REQ-009 Bubble condition: nop_mux=1 or ID_valid=0.
REQ-010 ID/EX update on a bubble: EX_Ctrl=0, EX_rs=0, EX_rt=0, EX_rd=0, EX_valid=0, EX_RegA/RegB/Imm=0.
REQ-011 ID/EX update otherwise:
- EX_Ctrl=ID_Ctrl; EX_RegA/RegB/Imm = corresponding inputs.
- EX_rs=ID_Instr[25:21], EX_rt=ID_Instr[20:16], EX_rd=ID_Instr[15:11].
- EX_valid=1.
REQ-012 nop_mux=1 SHALL insert a bubble regardless of ID_Write, and a bubble SHALL NOT alter IF/ID.
REQ-013 EX_MemRead SHALL be combinationally EX_Ctrl[7], so it is 0 during every bubble and the hazard unit cannot re-trigger on a bubble.
REQ-014 Latency: IF to ID is 1 cycle and ID to EX is 1 cycle; each stall cycle adds exactly 1 cycle.
REQ-015 stall_cnt SHALL increment by 1 on each posedge with ID_Write=0, saturating at 2^CNT_W-1 with no wrap.
REQ-016 flush_cnt SHALL increment by 1 on each accepted flush (flush=1 and ID_Write=1), saturating with no wrap.
REQ-017 A multi-cycle stall (ID_Write=0 for N cycles) SHALL hold IF/ID for all N cycles and add N to stall_cnt.

Reset
REQ-018 With reset=1 at a posedge, every registered output and both counters SHALL be 0 on the following cycle, including reset asserted mid-stall or mid-flush.
REQ-019 After reset deasserts, the first IF_Instr SHALL reach EX after 2 posedges.
REQ-020 No output SHALL be X after the first reset posedge.

Verification
REQ-021 Reset 2 cycles, ID_Write=1 -> all registered outputs 0, EX_valid=0, PC_Write=1, stall_cnt=0.
REQ-022 Load-use stall:
- Stimulus: IF/ID holds 0x01095020; drive ID_Write=0, nop_mux=1 for 1 cycle.
- Response: ID_Instr stays 0x01095020, EX_Ctrl=0, EX_valid=0, EX_MemRead=0, stall_cnt=1, PC_Write=0 during the stall.
- Next cycle: the instruction enters EX with EX_rd=10.
REQ-023 flush=1, ID_Write=1, IF_Instr=0x8C080004 -> next cycle ID_Instr=0; the cycle after, EX_valid=0; flush_cnt=1.
REQ-024 flush=1 with ID_Write=0 -> ID_Instr held, flush_cnt unchanged, stall_cnt increments by 1.
REQ-025 CNT_W=4, ID_Write=0 for 20 cycles -> stall_cnt=0xF and holds at 0xF.
REQ-026 reset=1 during the 2nd cycle of a 3-cycle stall -> next cycle ID_Instr=0, EX_valid=0, stall_cnt=0.
